// File: rtl/comm_master_q.sv
// Queued UART command master: buffers CMD_W-bit commands in a DEPTH-entry FIFO
// and sends each one as CMD_W/8 bytes of 8N1, most-significant byte first.
module comm_master_q #(
  parameter int CMD_W    = 16,
  parameter int DEPTH    = 4,
  parameter int BAUD_DIV = 2604
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       snd_cmd,
  input  logic [CMD_W-1:0]           cmd,
  input  logic                       clr_ovfl,
  output logic                       TX,
  output logic                       cmd_cmplt,
  output logic                       busy,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovfl
);

  localparam int NB = CMD_W / 8;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int YW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BAUD = BW'(BAUD_DIV - 1);
  localparam logic [YW-1:0] LAST_BYTE = YW'(NB - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_n;
  logic [BW-1:0]    baud_q, baud_n;
  logic [2:0]       bit_q, bit_n;
  logic [YW-1:0]    byte_q, byte_n;
  logic [CMD_W-1:0] shift_q, shift_n;
  logic [7:0]       cur_byte;
  logic             tx_n, cmplt_n;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             pop, push;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign busy  = (state_q != IDLE);

  // A pop frees a slot on the same edge, so a push to a full FIFO still lands.
  assign pop  = (state_q == IDLE) && !empty;
  assign push = snd_cmd && (!full || pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovfl   <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (snd_cmd && !push) ovfl <= 1'b1;
      else if (clr_ovfl)    ovfl <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, and a reset port would block RAM inference.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q + BW'(1);
    bit_n   = bit_q;
    byte_n  = byte_q;
    shift_n = shift_q;
    cmplt_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          state_n = START;
          shift_n = mem[rd_ptr];
          byte_n  = '0;
        end
      end
      START: begin
        if (baud_q == LAST_BAUD) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (baud_q == LAST_BAUD) begin
          baud_n = '0;
          if (bit_q == 3'd7) state_n = STOP;
          else               bit_n   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_q == LAST_BAUD) begin
          baud_n = '0;
          if (byte_q != LAST_BYTE) begin
            byte_n  = byte_q + YW'(1);
            shift_n = shift_q << 8;
            state_n = START;
          end else begin
            state_n = IDLE;
            cmplt_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // TX is registered, so it is derived from where the FSM is heading.
    cur_byte = shift_n[CMD_W-1 -: 8];
    tx_n     = 1'b1;
    if (state_n == START)     tx_n = 1'b0;
    else if (state_n == DATA) tx_n = cur_byte[bit_n];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      TX        <= 1'b1;
      cmd_cmplt <= 1'b0;
    end else begin
      state_q   <= state_n;
      baud_q    <= baud_n;
      bit_q     <= bit_n;
      byte_q    <= byte_n;
      shift_q   <= shift_n;
      TX        <= tx_n;
      cmd_cmplt <= cmplt_n;
    end
  end

endmodule

// File: tb/tb_comm_master_q.sv
// Bench for comm_master_q: a 16-bit instance checked against a byte-queue model
// with a UART decoder, and a 24-bit instance checked for byte order and timing.
module tb_comm_master_q;

  localparam int DEPTH = 4;
  localparam int BD16  = 4;
  localparam int BD24  = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst16, snd16, clr16;
  logic [15:0]   cmd16;
  logic          tx16, cmplt16, busy16, full16, empty16, ovfl16;
  logic [CW-1:0] count16;

  logic          rst24, snd24, clr24;
  logic [23:0]   cmd24;
  logic          tx24, cmplt24, busy24, full24, empty24, ovfl24;
  logic [CW-1:0] count24;

  comm_master_q #(.CMD_W(16), .DEPTH(DEPTH), .BAUD_DIV(BD16)) dut16 (
    .clk(clk), .rst(rst16), .snd_cmd(snd16), .cmd(cmd16), .clr_ovfl(clr16),
    .TX(tx16), .cmd_cmplt(cmplt16), .busy(busy16), .full(full16),
    .empty(empty16), .count(count16), .ovfl(ovfl16)
  );

  comm_master_q #(.CMD_W(24), .DEPTH(DEPTH), .BAUD_DIV(BD24)) dut24 (
    .clk(clk), .rst(rst24), .snd_cmd(snd24), .cmd(cmd24), .clr_ovfl(clr24),
    .TX(tx24), .cmd_cmplt(cmplt24), .busy(busy24), .full(full24),
    .empty(empty24), .count(count24), .ovfl(ovfl24)
  );

  int         total = 0;
  int         bad = 0;
  int         acc_cnt = 0;
  int         cmplt_cnt16 = 0;
  logic       exp_ovfl = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Model: a command is accepted iff at most DEPTH are outstanding (queued or in flight).
  task automatic cycle16(input logic p, input logic [15:0] c, input logic clr);
    logic acc;
    acc   = p && ((acc_cnt - cmplt_cnt16) <= DEPTH);
    snd16 = p;
    cmd16 = c;
    clr16 = clr;
    if (acc) begin
      acc_cnt++;
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[7:0]);
    end
    if (p && !acc)  exp_ovfl = 1'b1;
    else if (clr)   exp_ovfl = 1'b0;
    step();
    snd16 = 1'b0;
    clr16 = 1'b0;
  endtask

  task automatic drain16(input string tag);
    int n = 0;
    while (acc_cnt != cmplt_cnt16 && n < 4000) begin
      step();
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n < 4000), 64'd1);
    steps(3);
    check({tag, "_nbytes"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_byte"}, 64'(rx_q[i]), 64'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  always @(negedge clk) if (cmplt16 === 1'b1) cmplt_cnt16++;

  // UART 8N1 receiver for the 16-bit instance, sampling mid-bit.
  initial begin : uart_rx16
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst16 === 1'b0 && tx16 === 1'b0) begin
        repeat (BD16 / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD16) @(negedge clk);
          b[i] = tx16;
        end
        repeat (BD16) @(negedge clk);
        check("rx16_stop_bit", 64'(tx16), 64'd1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    int          n, busy_low, base, idx, j, bi;
    logic [23:0] got;
    logic [2:0]  starts, stops;

    rst16 = 1'b1; snd16 = 1'b0; clr16 = 1'b0; cmd16 = '0;
    rst24 = 1'b1; snd24 = 1'b0; clr24 = 1'b0; cmd24 = '0;
    steps(2);
    check("rst_tx",    64'(tx16),    64'd1);
    check("rst_cmplt", 64'(cmplt16), 64'd0);
    check("rst_busy",  64'(busy16),  64'd0);
    check("rst_full",  64'(full16),  64'd0);
    check("rst_empty", 64'(empty16), 64'd1);
    check("rst_count", 64'(count16), 64'd0);
    check("rst_ovfl",  64'(ovfl16),  64'd0);
    rst16 = 1'b0;
    rst24 = 1'b0;
    steps(2);

    // Single command: A5 then 01, 80 clocks from TX fall to cmd_cmplt.
    cycle16(1'b1, 16'hA501, 1'b0);
    check("t1_count",   64'(count16), 64'd1);
    check("t1_empty",   64'(empty16), 64'd0);
    check("t1_tx_pre",  64'(tx16),    64'd1);
    step();
    check("t1_tx_fall", 64'(tx16),    64'd0);
    check("t1_busy",    64'(busy16),  64'd1);
    check("t1_count0",  64'(count16), 64'd0);
    n = 0;
    busy_low = 0;
    while (cmplt16 !== 1'b1 && n < 1000) begin
      if (busy16 !== 1'b1) busy_low++;
      step();
      n++;
    end
    check("t1_cmplt_latency", 64'(n), 64'd80);
    check("t1_busy_hold",     64'(busy_low), 64'd0);
    check("t1_busy_fall",     64'(busy16), 64'd0);
    step();
    check("t1_cmplt_pulse",   64'(cmplt16), 64'd0);
    drain16("t1");

    // Three back-to-back commands.
    cycle16(1'b1, 16'h0001, 1'b0);
    check("t2_count_a", 64'(count16), 64'd1);
    cycle16(1'b1, 16'h1234, 1'b0);
    check("t2_count_b", 64'(count16), 64'd1);
    cycle16(1'b1, 16'hFFFF, 1'b0);
    check("t2_count_c", 64'(count16), 64'd2);
    base = cmplt_cnt16;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (cmplt16 !== 1'b1 && n < 1000) begin
        step();
        n++;
      end
      check("t2_cmplt_timeout", 64'(n < 1000), 64'd1);
      check("t2_tx_stop_end", 64'(tx16), 64'd1);
      step();
      if (k < 2) check("t2_one_clock_gap", 64'(tx16), 64'd0);
    end
    check("t2_cmplt_count", 64'(cmplt_cnt16 - base), 64'd3);
    drain16("t2");

    // Overflow: six pushes from idle, five accepted.
    base = cmplt_cnt16;
    for (int k = 0; k < 6; k++) cycle16(1'b1, 16'(16'h5A00 + k), 1'b0);
    check("t3_ovfl",  64'(ovfl16),  64'd1);
    check("t3_full",  64'(full16),  64'd1);
    check("t3_count", 64'(count16), 64'd4);
    cycle16(1'b0, 16'h0000, 1'b1);
    check("t3_ovfl_clr", 64'(ovfl16), 64'd0);

    // Push on a full FIFO on the same edge as the pop.
    n = 0;
    while (cmplt16 !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    check("t4_cmplt_timeout", 64'(n < 1000), 64'd1);
    cycle16(1'b1, 16'hBEEF, 1'b0);
    check("t4_count", 64'(count16), 64'd4);
    check("t4_ovfl",  64'(ovfl16),  64'd0);
    check("t4_full",  64'(full16),  64'd1);
    drain16("t4");
    check("t4_cmplt_count", 64'(cmplt_cnt16 - base), 64'd6);

    // Reset during the data bits of the second byte.
    cycle16(1'b1, 16'h1357, 1'b0);
    cycle16(1'b1, 16'h2468, 1'b0);
    cycle16(1'b1, 16'h9ABC, 1'b0);
    steps(50);
    rst16 = 1'b1;
    #1;
    check("t5_tx",    64'(tx16),    64'd1);
    check("t5_busy",  64'(busy16),  64'd0);
    check("t5_cmplt", 64'(cmplt16), 64'd0);
    check("t5_count", 64'(count16), 64'd0);
    check("t5_empty", 64'(empty16), 64'd1);
    check("t5_full",  64'(full16),  64'd0);
    steps(60);
    rx_q.delete();
    exp_q.delete();
    acc_cnt  = cmplt_cnt16;
    exp_ovfl = 1'b0;
    base     = cmplt_cnt16;
    rst16    = 1'b0;
    steps(200);
    check("t5_no_cmplt",    64'(cmplt_cnt16 - base), 64'd0);
    check("t5_empty_after", 64'(empty16), 64'd1);
    check("t5_tx_idle",     64'(tx16),    64'd1);
    check("t5_no_bytes",    64'(rx_q.size()), 64'd0);

    // Random pushes and clears against the capacity model.
    for (int k = 0; k < 1500; k++) begin
      cycle16(1'($urandom_range(0, 5) == 0), 16'($urandom), 1'($urandom_range(0, 7) == 0));
      check("rand_ovfl", 64'(ovfl16), 64'(exp_ovfl));
    end
    drain16("rand");

    // 24-bit instance: C0 FF EE, 90 clocks from TX fall to cmd_cmplt.
    cmd24 = 24'hC0FFEE;
    snd24 = 1'b1;
    step();
    snd24 = 1'b0;
    step();
    check("t6_tx_fall", 64'(tx24), 64'd0);
    n = 0;
    got = '0;
    starts = '1;
    stops = '0;
    while (cmplt24 !== 1'b1 && n < 1000) begin
      if (n % BD24 == 1 && n / BD24 < 30) begin
        idx = n / BD24;
        j   = idx % 10;
        bi  = idx / 10;
        if (j == 0)      starts[bi] = tx24;
        else if (j == 9) stops[bi]  = tx24;
        else             got[(2 - bi) * 8 + j - 1] = tx24;
      end
      step();
      n++;
    end
    check("t6_cmplt_latency", 64'(n), 64'd90);
    check("t6_bytes",  64'(got),    64'hC0FFEE);
    check("t6_starts", 64'(starts), 64'd0);
    check("t6_stops",  64'(stops),  64'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
